// File: rtl/div_sequencer_if.sv
// rtl/div_sequencer_if.sv - request/response bundle between Execute and the divide sequencer
interface div_sequencer_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, operand_a, operand_b, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, op, operand_a, operand_b, flush,
        output busy, done, result
    );
endinterface

// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - radix-2 restoring divider sequencer for DIV/DIVU/REM/REMU
module div_sequencer #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    div_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state, state_nxt;
    logic              rem_sel;
    logic [XLEN-1:0]   quo, rem, dvs, result_q;
    logic [CNT_W-1:0]  cnt;
    logic              qsign, rsign;

    logic              accept, is_signed, div_zero, ovf, special, last_iter;
    logic [XLEN-1:0]   abs_a, abs_b, special_res;
    logic [XLEN:0]     sh, diff;
    logic [XLEN-1:0]   quo_nxt, rem_nxt, quo_fix, rem_fix;

    always_comb begin
        accept    = (state == IDLE) && bus.start && !bus.flush;
        is_signed = !bus.op[0];
        div_zero  = (bus.operand_b == '0);
        ovf       = is_signed && (bus.operand_a == MIN_NEG) && (bus.operand_b == '1);
        special   = div_zero || ovf;
        if (div_zero)
            special_res = bus.op[1] ? bus.operand_a : '1;
        else
            special_res = bus.op[1] ? '0 : MIN_NEG;
        abs_a = (is_signed && bus.operand_a[XLEN-1]) ? -bus.operand_a : bus.operand_a;
        abs_b = (is_signed && bus.operand_b[XLEN-1]) ? -bus.operand_b : bus.operand_b;

        // Partial remainder grows one bit before the trial subtract, hence XLEN+1 bits.
        sh      = {rem, quo[XLEN-1]};
        diff    = sh - {1'b0, dvs};
        rem_nxt = diff[XLEN] ? sh[XLEN-1:0] : diff[XLEN-1:0];
        quo_nxt = {quo[XLEN-2:0], ~diff[XLEN]};
        quo_fix = qsign ? -quo_nxt : quo_nxt;
        rem_fix = rsign ? -rem_nxt : rem_nxt;
        last_iter = (cnt == CNT_W'(XLEN-1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = special ? DONE : CALC;
            CALC: begin
                if (bus.flush)
                    state_nxt = IDLE;
                else if (last_iter)
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy   = (state != IDLE);
        bus.done   = (state == DONE) && !bus.flush;
        bus.result = result_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_sel  <= 1'b0;
            quo      <= '0;
            rem      <= '0;
            dvs      <= '0;
            cnt      <= '0;
            qsign    <= 1'b0;
            rsign    <= 1'b0;
            result_q <= '0;
        end else if (accept) begin
            rem_sel <= bus.op[1];
            quo     <= abs_a;
            dvs     <= abs_b;
            rem     <= '0;
            cnt     <= '0;
            qsign   <= is_signed && (bus.operand_a[XLEN-1] ^ bus.operand_b[XLEN-1]);
            rsign   <= is_signed && bus.operand_a[XLEN-1];
            if (special)
                result_q <= special_res;
        end else if (state == CALC && !bus.flush) begin
            quo <= quo_nxt;
            rem <= rem_nxt;
            cnt <= cnt + 1'b1;
            if (last_iter)
                result_q <= rem_sel ? rem_fix : quo_fix;
        end
    end
endmodule

// File: tb/tb_div_sequencer.sv
// tb/tb_div_sequencer.sv - randomized self-checking bench for div_sequencer
module tb_div_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    div_sequencer_if #(.XLEN(32)) bus();

    div_sequencer #(.XLEN(32), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
        case (o)
            2'd0:    return $signed(a) / $signed(b);
            2'd1:    return a / b;
            2'd2:    return $signed(a) % $signed(b);
            default: return a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 0;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        return 32;
    endfunction

    // Issues one op from IDLE (called at posedge+1); lat = edges after the accept edge until done.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output int lat, output bit busy_ok);
        bus.start = 1'b1; bus.op = o; bus.operand_a = a; bus.operand_b = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 0;
        busy_ok = 1'b1;
        while (!bus.done && lat < 100) begin
            if (!bus.busy) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        r = bus.result;
        if (!bus.busy) busy_ok = 1'b0;
        @(posedge clk); #1;
        if (bus.busy) busy_ok = 1'b0;
    endtask

    task automatic test_reset;
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'd0) begin
            n_bad++;
            $display("FAIL reset: busy=%b done=%b result=%h required 0/0/0", bus.busy, bus.done, bus.result);
        end
    endtask

    task automatic test_unsigned;
        logic [31:0] r; int lat; bit ok;
        do_op(2'd1, 32'd100, 32'd7, r, lat, ok);
        n_cmp++;
        if (r !== 32'd14 || lat !== 32 || ok !== 1'b1) begin
            n_bad++;
            $display("FAIL divu_100_7: result=%h lat=%0d busy_ok=%b required 0000000e/32/1", r, lat, ok);
        end
        do_op(2'd3, 32'd100, 32'd7, r, lat, ok);
        n_cmp++;
        if (r !== 32'd2 || lat !== 32 || ok !== 1'b1) begin
            n_bad++;
            $display("FAIL remu_100_7: result=%h lat=%0d busy_ok=%b required 00000002/32/1", r, lat, ok);
        end
    endtask

    task automatic test_signed;
        logic [1:0]  ops [4] = '{2'd0, 2'd2, 2'd0, 2'd2};
        logic [31:0] as  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd7};
        logic [31:0] bs  [4] = '{32'd2, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
        logic [31:0] exp [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd1};
        logic [31:0] r; int lat; bit ok;
        for (int i = 0; i < 4; i++) begin
            do_op(ops[i], as[i], bs[i], r, lat, ok);
            n_cmp++;
            if (r !== exp[i] || lat !== 32 || ok !== 1'b1) begin
                n_bad++;
                $display("FAIL signed_%0d: result=%h lat=%0d busy_ok=%b required %h/32/1", i, r, lat, ok, exp[i]);
            end
        end
    endtask

    task automatic test_special;
        logic [1:0]  ops [4] = '{2'd1, 2'd3, 2'd0, 2'd2};
        logic [31:0] as  [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exp [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        logic [31:0] r; int lat; bit ok;
        for (int i = 0; i < 4; i++) begin
            do_op(ops[i], as[i], bs[i], r, lat, ok);
            n_cmp++;
            if (r !== exp[i] || lat !== 0 || ok !== 1'b1) begin
                n_bad++;
                $display("FAIL special_%0d: result=%h lat=%0d busy_ok=%b required %h/0/1", i, r, lat, ok, exp[i]);
            end
        end
    endtask

    task automatic test_ignore_start_and_flush;
        int lat; bit seen_done; logic [31:0] r; bit ok;
        bus.start = 1'b1; bus.op = 2'd1; bus.operand_a = 32'd1000; bus.operand_b = 32'd10;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        bus.start = 1'b1; bus.op = 2'd3; bus.operand_a = 32'd77; bus.operand_b = 32'd5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 10;
        while (!bus.done && lat < 100) begin @(posedge clk); #1; lat++; end
        n_cmp++;
        if (bus.result !== 32'd100 || lat !== 32) begin
            n_bad++;
            $display("FAIL ignore_start: result=%h lat=%0d required 00000064/32", bus.result, lat);
        end
        @(posedge clk); #1;

        bus.start = 1'b1; bus.op = 2'd1; bus.operand_a = 32'd999; bus.operand_b = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_idle: busy=%b done=%b required 0/0", bus.busy, bus.done);
        end
        seen_done = 1'b0;
        repeat (40) begin
            if (bus.done) seen_done = 1'b1;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (seen_done !== 1'b0 || bus.result !== 32'd100) begin
            n_bad++;
            $display("FAIL flush_no_done: done_seen=%b result=%h required 0/00000064", seen_done, bus.result);
        end
        do_op(2'd1, 32'd999, 32'd3, r, lat, ok);
        n_cmp++;
        if (r !== 32'd333 || lat !== 32 || ok !== 1'b1) begin
            n_bad++;
            $display("FAIL after_flush: result=%h lat=%0d busy_ok=%b required 0000014d/32/1", r, lat, ok);
        end
        // flush together with start in IDLE must not accept anything
        bus.start = 1'b1; bus.flush = 1'b1; bus.op = 2'd1; bus.operand_a = 32'd8; bus.operand_b = 32'd0;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.flush = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'd333) begin
            n_bad++;
            $display("FAIL flush_wins: busy=%b done=%b result=%h required 0/0/0000014d", bus.busy, bus.done, bus.result);
        end
    endtask

    task automatic test_async_reset;
        logic [31:0] r; int lat; bit ok;
        bus.start = 1'b1; bus.op = 2'd1; bus.operand_a = 32'd12345; bus.operand_b = 32'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'd0) begin
            n_bad++;
            $display("FAIL async_reset: busy=%b done=%b result=%h required 0/0/0", bus.busy, bus.done, bus.result);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(2'd1, 32'hFFFF_FFFF, 32'd1, r, lat, ok);
        n_cmp++;
        if (r !== 32'hFFFF_FFFF || lat !== 32 || ok !== 1'b1) begin
            n_bad++;
            $display("FAIL after_reset: result=%h lat=%0d busy_ok=%b required ffffffff/32/1", r, lat, ok);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        bus.start = 1'b1; bus.op = 2'd1; bus.operand_a = 32'd50; bus.operand_b = 32'd6;
        @(posedge clk); #1;
        bus.op = 2'd2; bus.operand_a = 32'hFFFF_FF9C; bus.operand_b = 32'd7;
        lat = 0;
        while (!bus.done && lat < 100) begin @(posedge clk); #1; lat++; end
        n_cmp++;
        if (bus.result !== 32'd8 || lat !== 32) begin
            n_bad++;
            $display("FAIL b2b_first: result=%h lat=%0d required 00000008/32", bus.result, lat);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_idle: busy=%b required 0", bus.busy);
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_accept: busy=%b required 1", bus.busy);
        end
        lat = 0;
        while (!bus.done && lat < 100) begin @(posedge clk); #1; lat++; end
        n_cmp++;
        if (bus.result !== 32'hFFFF_FFFE || lat !== 32) begin
            n_bad++;
            $display("FAIL b2b_second: result=%h lat=%0d required fffffffe/32", bus.result, lat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random_sweep;
        logic [31:0] pool [5] = '{32'd0, 32'd1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] a, b, r, exp;
        logic [1:0]  o;
        int lat, exp_lat;
        bit ok;
        for (int i = 0; i < 1000; i++) begin
            o = 2'($urandom_range(0, 3));
            a = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 4)] : $urandom;
            case ($urandom_range(0, 3))
                0:       b = pool[$urandom_range(0, 4)];
                1:       b = $urandom_range(1, 300) * (($urandom_range(0, 1) == 0) ? 1 : -1);
                default: b = $urandom;
            endcase
            exp     = ref_model(o, a, b);
            exp_lat = ref_latency(o, a, b);
            do_op(o, a, b, r, lat, ok);
            n_cmp++;
            if (r !== exp || lat !== exp_lat || ok !== 1'b1) begin
                n_bad++;
                $display("FAIL sweep_%0d op=%0d a=%h b=%h: result=%h lat=%0d busy_ok=%b required %h/%0d/1",
                         i, o, a, b, r, lat, ok, exp, exp_lat);
            end
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.op = 2'd0; bus.operand_a = '0; bus.operand_b = '0; bus.flush = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_unsigned();
        test_signed();
        test_special();
        test_ignore_start_and_flush();
        test_async_reset();
        test_back_to_back();
        test_random_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
